// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame decoder.
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StData,
    StCsum,
    StWrite,
    StReadReq,
    StReadWait,
    StTxLoad,
    StTxWait
  } cmd_state_t;

  localparam logic [7:0]  ACK_BYTE    = 8'h06;
  localparam logic [7:0]  NAK_BYTE    = 8'h15;
  localparam int unsigned RD_FLAG_BIT = 7;

endpackage

// File: rtl/uart_resp_sender.sv
// Response byte queue and transmit handshake: holds up to MaxLen bytes and
// walks them out through txStart/txDone while the decoder sits in its TX states.
module uart_resp_sender #(
  parameter int unsigned MaxLen = 5,
  parameter int unsigned IdxW   = 3
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   load_i,
  input  logic [IdxW-1:0]        load_len_i,
  input  logic [MaxLen-1:0][7:0] load_bytes_i,
  input  logic                   in_load_i,
  input  logic                   in_wait_i,
  input  logic                   tx_busy_i,
  input  logic                   tx_done_i,
  output logic [7:0]             tx_data_o,
  output logic                   tx_start_o,
  output logic                   last_o
);

  logic [MaxLen-1:0][7:0] resp_q, resp_d;
  logic [IdxW-1:0]        len_q, len_d;
  logic [IdxW-1:0]        idx_q, idx_d;

  always_comb begin
    resp_d = resp_q;
    len_d  = len_q;
    idx_d  = idx_q;
    if (load_i) begin
      resp_d = load_bytes_i;
      len_d  = load_len_i;
      idx_d  = '0;
    end else if (in_wait_i && tx_done_i) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      resp_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
    end else begin
      resp_q <= resp_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
    end
  end

  // Start is gated by txBusy combinationally so it can never overlap a busy transmitter.
  assign tx_start_o = in_load_i & ~tx_busy_i;
  assign tx_data_o  = (in_load_i || in_wait_i) ? resp_q[idx_q] : 8'h00;
  assign last_o     = (IdxW'(idx_q + 1'b1) == len_q);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Host-to-register bridge: parses SYNC/addr/data/csum frames from the UART,
// drives the register bus and queues ACK/NAK/read-data responses.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned DataBytes     = 4,
  parameter int unsigned AddrWidth     = 7,
  parameter int unsigned TimeoutCycles = 20000,
  parameter logic [7:0]  SyncByte      = 8'hA5
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [7:0]             rx_data_i,
  input  logic                   rx_valid_i,
  output logic [7:0]             tx_data_o,
  output logic                   tx_start_o,
  input  logic                   tx_busy_i,
  input  logic                   tx_done_i,
  output logic [AddrWidth-1:0]   reg_addr_o,
  output logic [8*DataBytes-1:0] reg_wr_data_o,
  output logic                   reg_wr_en_o,
  output logic                   reg_rd_en_o,
  input  logic [8*DataBytes-1:0] reg_rd_data_i,
  input  logic                   reg_rd_valid_i,
  output logic                   frame_error_o,
  output logic                   busy_o
);

  localparam int unsigned RespLen  = DataBytes + 1;
  localparam int unsigned IdxW     = $clog2(DataBytes + 2);
  localparam int unsigned CntW     = $clog2(TimeoutCycles + 1);
  localparam int unsigned ByteIdxW = (DataBytes > 1) ? $clog2(DataBytes) : 1;

  cmd_state_t                 state_q, state_d;
  logic [7:0]                 addr_q, addr_d;
  logic [7:0]                 csum_q, csum_d;
  logic [DataBytes-1:0][7:0]  data_q, data_d;
  logic [ByteIdxW-1:0]        byte_idx_q, byte_idx_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic                       frame_err_q, frame_err_d;

  logic                       load;
  logic [IdxW-1:0]            load_len;
  logic [RespLen-1:0][7:0]    load_bytes;
  logic [7:0]                 rd_csum;
  logic                       timeout;
  logic                       tx_start;
  logic                       tx_last;

  assign timeout = (cnt_q == CntW'(TimeoutCycles - 1));

  always_comb begin
    rd_csum = addr_q;
    for (int i = 0; i < DataBytes; i++) begin
      rd_csum = rd_csum ^ reg_rd_data_i[8*i +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    csum_d      = csum_q;
    data_d      = data_q;
    byte_idx_d  = byte_idx_q;
    cnt_d       = cnt_q + 1'b1;
    frame_err_d = 1'b0;
    load        = 1'b0;
    load_len    = '0;
    load_bytes  = '0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (rx_valid_i && rx_data_i == SyncByte) state_d = StAddr;
      end
      StAddr: begin
        if (rx_valid_i) begin
          addr_d     = rx_data_i;
          csum_d     = rx_data_i;
          cnt_d      = '0;
          byte_idx_d = '0;
          state_d    = rx_data_i[RD_FLAG_BIT] ? StCsum : StData;
        end else if (timeout) begin
          frame_err_d = 1'b1;
          state_d     = StIdle;
        end
      end
      StData: begin
        if (rx_valid_i) begin
          data_d[byte_idx_q] = rx_data_i;
          csum_d             = csum_q ^ rx_data_i;
          cnt_d              = '0;
          byte_idx_d         = byte_idx_q + 1'b1;
          if (byte_idx_q == ByteIdxW'(DataBytes - 1)) state_d = StCsum;
        end else if (timeout) begin
          frame_err_d = 1'b1;
          state_d     = StIdle;
        end
      end
      StCsum: begin
        if (rx_valid_i) begin
          cnt_d = '0;
          if (rx_data_i == csum_q) begin
            state_d = addr_q[RD_FLAG_BIT] ? StReadReq : StWrite;
          end else begin
            frame_err_d   = 1'b1;
            load          = 1'b1;
            load_len      = IdxW'(1);
            load_bytes[0] = NAK_BYTE;
            state_d       = StTxLoad;
          end
        end else if (timeout) begin
          frame_err_d = 1'b1;
          state_d     = StIdle;
        end
      end
      StWrite: begin
        load          = 1'b1;
        load_len      = IdxW'(1);
        load_bytes[0] = ACK_BYTE;
        state_d       = StTxLoad;
      end
      StReadReq: begin
        cnt_d   = '0;
        state_d = StReadWait;
      end
      StReadWait: begin
        // Read data wins over a coincident timeout.
        if (reg_rd_valid_i) begin
          load     = 1'b1;
          load_len = IdxW'(RespLen);
          for (int i = 0; i < DataBytes; i++) begin
            load_bytes[i] = reg_rd_data_i[8*i +: 8];
          end
          load_bytes[DataBytes] = rd_csum;
          state_d               = StTxLoad;
        end else if (timeout) begin
          frame_err_d   = 1'b1;
          load          = 1'b1;
          load_len      = IdxW'(1);
          load_bytes[0] = NAK_BYTE;
          state_d       = StTxLoad;
        end
      end
      StTxLoad: begin
        if (tx_start) state_d = StTxWait;
      end
      StTxWait: begin
        if (tx_done_i) state_d = tx_last ? StIdle : StTxLoad;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      csum_q      <= '0;
      data_q      <= '0;
      byte_idx_q  <= '0;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      csum_q      <= csum_d;
      data_q      <= data_d;
      byte_idx_q  <= byte_idx_d;
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  uart_resp_sender #(
    .MaxLen (RespLen),
    .IdxW   (IdxW)
  ) u_resp_sender (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .load_i       (load),
    .load_len_i   (load_len),
    .load_bytes_i (load_bytes),
    .in_load_i    (state_q == StTxLoad),
    .in_wait_i    (state_q == StTxWait),
    .tx_busy_i    (tx_busy_i),
    .tx_done_i    (tx_done_i),
    .tx_data_o    (tx_data_o),
    .tx_start_o   (tx_start),
    .last_o       (tx_last)
  );

  assign tx_start_o    = tx_start;
  assign reg_addr_o    = addr_q[AddrWidth-1:0];
  assign reg_wr_data_o = data_q;
  assign reg_wr_en_o   = (state_q == StWrite);
  assign reg_rd_en_o   = (state_q == StReadReq);
  assign frame_error_o = frame_err_q;
  assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomized self-checking bench for uart_cmd_decoder: frames are scored
// against a byte-level protocol model with transmitter and register-bus models.
module tb_uart_cmd_decoder;

  localparam int unsigned Timeout = 100;
  localparam logic [7:0]  Sync    = 8'hA5;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        tx_done;
  logic [6:0]  reg_addr;
  logic [31:0] reg_wr_data;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [31:0] reg_rd_data;
  logic        reg_rd_valid;
  logic        frame_error;
  logic        busy;

  always #5 clk = ~clk;

  uart_cmd_decoder #(
    .DataBytes     (4),
    .AddrWidth     (7),
    .TimeoutCycles (Timeout),
    .SyncByte      (Sync)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .rx_data_i      (rx_data),
    .rx_valid_i     (rx_valid),
    .tx_data_o      (tx_data),
    .tx_start_o     (tx_start),
    .tx_busy_i      (tx_busy),
    .tx_done_i      (tx_done),
    .reg_addr_o     (reg_addr),
    .reg_wr_data_o  (reg_wr_data),
    .reg_wr_en_o    (reg_wr_en),
    .reg_rd_en_o    (reg_rd_en),
    .reg_rd_data_i  (reg_rd_data),
    .reg_rd_valid_i (reg_rd_valid),
    .frame_error_o  (frame_error),
    .busy_o         (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Environment knobs, written only by the main sequence.
  int          tx_lat     = 2;
  int          rd_lat     = 10;
  bit          rd_respond = 1'b1;
  logic [31:0] rd_val     = 32'h0;

  // Observations, written only by the monitor/models.
  logic [7:0]  cap_q[$];
  int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
  int          start_busy_cnt = 0, stab_err = 0;
  logic [6:0]  last_wr_addr = '0, last_rd_addr = '0;
  logic [31:0] last_wr_data = '0;

  logic [7:0]  frm[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reg_wr_en) begin
      wr_cnt++;
      last_wr_addr = reg_addr;
      last_wr_data = reg_wr_data;
    end
    if (reg_rd_en) begin
      rd_cnt++;
      last_rd_addr = reg_addr;
    end
    if (frame_error) err_cnt++;
  end

  // Transmitter: a start seen at a negedge is taken on the following posedge.
  initial begin
    logic [7:0] cur;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (tx_start) begin
        cap_q.push_back(tx_data);
        cur = tx_data;
        @(negedge clk);
        tx_busy = 1'b1;
        for (int i = 0; i < tx_lat; i++) begin
          @(negedge clk);
          if (tx_start) start_busy_cnt++;
          if (busy && tx_data !== cur) stab_err++;
        end
        tx_busy = 1'b0;
        tx_done = 1'b1;
      end
    end
  end

  initial begin
    reg_rd_valid = 1'b0;
    reg_rd_data  = '0;
    forever begin
      @(negedge clk);
      if (reg_rd_en && rd_respond) begin
        repeat (rd_lat) @(negedge clk);
        reg_rd_data  = rd_val;
        reg_rd_valid = 1'b1;
        @(negedge clk);
        reg_rd_valid = 1'b0;
        reg_rd_data  = $urandom;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "/idle"}, 64'(busy), 64'(0));
  endtask

  task automatic make_frame(input bit rd, input logic [6:0] a, input logic [31:0] d,
                            input logic [7:0] corrupt);
    logic [7:0] cs;
    frm.delete();
    cs = {rd, a};
    frm.push_back({rd, a});
    if (!rd) begin
      for (int i = 0; i < 4; i++) begin
        frm.push_back(d[8*i +: 8]);
        cs = cs ^ d[8*i +: 8];
      end
    end
    frm.push_back(cs ^ corrupt);
  endtask

  // Expected behaviour derived from the frame bytes and the register-bus knobs.
  task automatic run_frame(input string tag, input int junk, input int gap_max);
    logic [7:0]  exp_q[$];
    logic [7:0]  addr, cs, b;
    logic [31:0] wd;
    bit          rd, ok, exp_err;
    int          nb, b_tx, b_wr, b_rd, b_err;
    addr = frm[0];
    rd   = addr[7];
    nb   = rd ? 0 : 4;
    cs   = addr;
    wd   = '0;
    for (int i = 1; i <= nb; i++) begin
      cs = cs ^ frm[i];
      wd[8*(i-1) +: 8] = frm[i];
    end
    ok      = (frm[nb+1] == cs);
    exp_err = !ok || (rd && !rd_respond);
    if (exp_err) exp_q.push_back(8'h15);
    else if (!rd) exp_q.push_back(8'h06);
    else begin
      cs = addr;
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back(rd_val[8*i +: 8]);
        cs = cs ^ rd_val[8*i +: 8];
      end
      exp_q.push_back(cs);
    end
    b_tx  = cap_q.size();
    b_wr  = wr_cnt;
    b_rd  = rd_cnt;
    b_err = err_cnt;
    for (int j = 0; j < junk; j++) begin
      b = 8'($urandom);
      if (b == Sync) b = 8'h00;
      send_byte(b, $urandom_range(0, gap_max));
    end
    send_byte(Sync, $urandom_range(0, gap_max));
    foreach (frm[i]) send_byte(frm[i], $urandom_range(0, gap_max));
    wait_idle(tag, 3000);
    repeat (3) @(negedge clk);
    check_eq({tag, "/tx_len"}, 64'(cap_q.size() - b_tx), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && b_tx + i < cap_q.size(); i++)
      check_eq($sformatf("%s/tx_byte%0d", tag, i), 64'(cap_q[b_tx+i]), 64'(exp_q[i]));
    check_eq({tag, "/wr_cnt"}, 64'(wr_cnt - b_wr), 64'(ok && !rd));
    check_eq({tag, "/rd_cnt"}, 64'(rd_cnt - b_rd), 64'(ok && rd));
    check_eq({tag, "/err_cnt"}, 64'(err_cnt - b_err), 64'(exp_err));
    if (ok && !rd) begin
      check_eq({tag, "/wr_addr"}, 64'(last_wr_addr), 64'(addr[6:0]));
      check_eq({tag, "/wr_data"}, 64'(last_wr_data), 64'(wd));
    end
    if (ok && rd) check_eq({tag, "/rd_addr"}, 64'(last_rd_addr), 64'(addr[6:0]));
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "/ctl"}, 64'({tx_start, tx_data, reg_wr_en, reg_rd_en, frame_error, busy,
                                 reg_addr}), 64'(0));
    check_eq({tag, "/wr_data"}, 64'(reg_wr_data), 64'(0));
  endtask

  initial begin
    int base, b_err, n;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Reference write vector.
    frm = '{8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h41};
    tx_lat = 3;
    run_frame("write", 0, 0);

    rd_val = 32'hDEADBEEF;
    rd_lat = 10;
    frm    = '{8'h85, 8'h85};
    run_frame("read", 0, 0);

    frm = '{8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    run_frame("bad_csum", 0, 1);

    // Stall mid-frame: silent drop after the inter-byte timeout.
    base  = cap_q.size();
    b_err = err_cnt;
    send_byte(Sync, 0);
    send_byte(8'h05, 0);
    send_byte(8'h11, 0);
    check_eq("stall/busy_mid", 64'(busy), 64'(1));
    repeat (Timeout + 20) @(negedge clk);
    check_eq("stall/err_cnt", 64'(err_cnt - b_err), 64'(1));
    check_eq("stall/tx_len", 64'(cap_q.size() - base), 64'(0));
    check_eq("stall/busy", 64'(busy), 64'(0));
    make_frame(1'b0, 7'h12, 32'hCAFE_F00D, 8'h00);
    run_frame("after_stall", 0, 2);

    send_byte(8'h00, 0);
    send_byte(8'hFF, 1);
    make_frame(1'b0, 7'h33, 32'hA5A5_00A5, 8'h00);
    run_frame("junk_sync_data", 0, 0);

    rd_respond = 1'b0;
    make_frame(1'b1, 7'h21, 32'h0, 8'h00);
    run_frame("read_timeout", 0, 0);
    rd_respond = 1'b1;

    // Reset while the second response byte is on the wire.
    rd_val = 32'h0123_4567;
    rd_lat = 3;
    tx_lat = 6;
    base   = cap_q.size();
    send_byte(Sync, 0);
    send_byte(8'h85, 0);
    send_byte(8'h85, 0);
    n = 0;
    while (cap_q.size() < base + 2 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_mid/second_start", 64'(cap_q.size() >= base + 2), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("rst_mid");
    reset = 1'b0;
    repeat (60) @(negedge clk);
    check_eq("rst_mid/no_more_tx", 64'(cap_q.size() - base), 64'(2));
    check_eq("rst_mid/busy", 64'(busy), 64'(0));

    for (int k = 0; k < 24; k++) begin
      bit rd;
      rd         = 1'($urandom);
      rd_val     = $urandom;
      rd_lat     = $urandom_range(1, 20);
      tx_lat     = $urandom_range(1, 6);
      rd_respond = !(rd && $urandom_range(0, 5) == 0);
      make_frame(rd, 7'($urandom), $urandom,
                 ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
      run_frame($sformatf("rand%0d", k), $urandom_range(0, 2), 4);
    end
    rd_respond = 1'b1;

    check_eq("tx_start_while_busy", 64'(start_busy_cnt), 64'(0));
    check_eq("tx_data_stable", 64'(stab_err), 64'(0));

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
